// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and data-phase types for the response mux.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned NUM_SLAVES = 4;
  localparam int unsigned DSEL_W     = NUM_SLAVES + 1;

  // Bit positions inside the one-hot data-phase select.
  typedef enum logic [2:0] {
    DselS0  = 3'd0,
    DselS1  = 3'd1,
    DselS2  = 3'd2,
    DselS3  = 3'd3,
    DselDef = 3'd4
  } dsel_idx_e;

  // Error sequencer states; the watchdog reuses the same two-cycle ERROR.
  typedef enum logic [2:0] {
    DsIdle = 3'd0,
    DsErr1 = 3'd1,
    DsErr2 = 3'd2,
    WdErr1 = 3'd3,
    WdErr2 = 3'd4
  } ds_state_e;

endpackage

// File: rtl/ahb_lite_default_slave.sv
// Two-cycle ERROR sequencer: serves unmapped accesses and watchdog overrides.
module ahb_lite_default_slave
  import ahb_lite_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic start_def,
  input  logic start_wd,
  output logic active,
  output logic hready,
  output logic hresp,
  output logic irq
);

  ds_state_e st_q, st_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= DsIdle;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      DsIdle: begin
        if (start_wd) begin
          st_d = WdErr1;
        end else if (capture && start_def) begin
          st_d = DsErr1;
        end
      end
      DsErr1: st_d = DsErr2;
      WdErr1: st_d = WdErr2;
      // Second ERROR cycle is also an address phase; back-to-back unmapped restarts.
      DsErr2, WdErr2: begin
        if (capture && start_def) begin
          st_d = DsErr1;
        end else begin
          st_d = DsIdle;
        end
      end
      default: st_d = DsIdle;
    endcase
  end

  always_comb begin
    active = (st_q != DsIdle);
    hready = !(st_q == DsErr1 || st_q == WdErr1);
    hresp  = active ? HRESP_ERROR : HRESP_OKAY;
    irq    = (st_q == WdErr1);
  end

endmodule

// File: rtl/ahb_lite_resp_mux.sv
// AHB-Lite data-phase controller: select register, response mux, default slave
// and wait-state watchdog.
module ahb_lite_resp_mux
  import ahb_lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL0,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic                  HSEL3,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA0,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic [DATA_WIDTH-1:0] HRDATA3,
  input  logic                  HREADYOUT0,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HREADYOUT3,
  input  logic                  HRESP0,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  input  logic                  HRESP3,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic                  TIMEOUT_IRQ
);

  localparam bit              WdEn   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DSEL_W-1:0]     dsel_q, dsel_d;
  logic [CNT_W-1:0]      wcnt_q, wcnt_d;
  logic [NUM_SLAVES-1:0] rdy_vec, resp_vec;
  logic [DATA_WIDTH-1:0] rdata_arr [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] slave_rdata;
  logic                  slave_ready, slave_resp;
  logic                  wait_cyc, start_wd;
  logic                  ds_active, ds_hready, ds_hresp, ds_irq;

  assign rdy_vec      = {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0};
  assign resp_vec     = {HRESP3, HRESP2, HRESP1, HRESP0};
  assign rdata_arr[0] = HRDATA0;
  assign rdata_arr[1] = HRDATA1;
  assign rdata_arr[2] = HRDATA2;
  assign rdata_arr[3] = HRDATA3;

  // Lowest-index select wins; unmapped NONSEQ/SEQ goes to the default slave.
  always_comb begin
    dsel_d = '0;
    if (HSEL0) begin
      dsel_d[DselS0] = 1'b1;
    end else if (HSEL1) begin
      dsel_d[DselS1] = 1'b1;
    end else if (HSEL2) begin
      dsel_d[DselS2] = 1'b1;
    end else if (HSEL3) begin
      dsel_d[DselS3] = 1'b1;
    end else if (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) begin
      dsel_d[DselDef] = 1'b1;
    end
  end

  always_comb begin
    slave_rdata = '0;
    slave_ready = 1'b1;
    slave_resp  = HRESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        slave_rdata = rdata_arr[i];
        slave_ready = rdy_vec[i];
        slave_resp  = resp_vec[i];
      end
    end
  end

  // The sequencer owns the bus whenever it is active; slave outputs are ignored.
  always_comb begin
    if (ds_active) begin
      HRDATA = '0;
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end else begin
      HRDATA = slave_rdata;
      HREADY = slave_ready;
      HRESP  = slave_resp;
    end
    TIMEOUT_IRQ = ds_irq;
  end

  assign wait_cyc = !ds_active && !slave_ready;
  assign start_wd = WdEn && wait_cyc && (wcnt_q == WdLast);

  always_comb begin
    wcnt_d = wcnt_q;
    if (HREADY) begin
      wcnt_d = '0;
    end else if (wait_cyc && wcnt_q != CntMax) begin
      wcnt_d = wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dsel_q <= '0;
      wcnt_q <= '0;
    end else begin
      if (HREADY) begin
        dsel_q <= dsel_d;
      end
      wcnt_q <= wcnt_d;
    end
  end

  ahb_lite_default_slave u_default_slave (
    .clk       (HCLK),
    .rst       (HRESET),
    .capture   (HREADY),
    .start_def (dsel_d[DselDef]),
    .start_wd  (start_wd),
    .active    (ds_active),
    .hready    (ds_hready),
    .hresp     (ds_hresp),
    .irq       (ds_irq)
  );

endmodule

// File: tb/tb_ahb_lite_resp_mux.sv
// Directed self-checking bench for ahb_lite_resp_mux (watchdog TIMEOUT = 4).
module tb_ahb_lite_resp_mux;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL0, HSEL1, HSEL2, HSEL3;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA0, HRDATA1, HRDATA2, HRDATA3;
  logic        HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3;
  logic        HRESP0, HRESP1, HRESP2, HRESP3;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, TIMEOUT_IRQ;

  int errors = 0;
  int checks = 0;

  ahb_lite_resp_mux #(
    .DATA_WIDTH (32),
    .TIMEOUT    (4),
    .CNT_W      (8)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL0       (HSEL0),
    .HSEL1       (HSEL1),
    .HSEL2       (HSEL2),
    .HSEL3       (HSEL3),
    .HTRANS      (HTRANS),
    .HRDATA0     (HRDATA0),
    .HRDATA1     (HRDATA1),
    .HRDATA2     (HRDATA2),
    .HRDATA3     (HRDATA3),
    .HREADYOUT0  (HREADYOUT0),
    .HREADYOUT1  (HREADYOUT1),
    .HREADYOUT2  (HREADYOUT2),
    .HREADYOUT3  (HREADYOUT3),
    .HRESP0      (HRESP0),
    .HRESP1      (HRESP1),
    .HRESP2      (HRESP2),
    .HRESP3      (HRESP3),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .TIMEOUT_IRQ (TIMEOUT_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL0 = 1'b0; HSEL1 = 1'b0; HSEL2 = 1'b0; HSEL3 = 1'b0;
    HTRANS = 2'b00;
  endtask

  task automatic check_resp(input string tag, input logic rdy, input logic rsp,
                            input logic irq);
    check_eq({tag, ".hready"}, 32'(HREADY), 32'(rdy));
    check_eq({tag, ".hresp"}, 32'(HRESP), 32'(rsp));
    check_eq({tag, ".irq"}, 32'(TIMEOUT_IRQ), 32'(irq));
  endtask

  initial begin
    HRESET = 1'b1;
    bus_idle();
    HRDATA0 = '0; HRDATA1 = '0; HRDATA2 = '0; HRDATA3 = '0;
    HREADYOUT0 = 1'b1; HREADYOUT1 = 1'b1; HREADYOUT2 = 1'b1; HREADYOUT3 = 1'b1;
    HRESP0 = 1'b0; HRESP1 = 1'b0; HRESP2 = 1'b0; HRESP3 = 1'b0;
    #12;
    check_resp("reset", 1'b1, 1'b0, 1'b0);
    check_eq("reset.hrdata", HRDATA, 32'h0);
    check_eq("reset.dsel", 32'(dut.dsel_q), 32'h0);
    check_eq("reset.wcnt", 32'(dut.wcnt_q), 32'h0);
    HRESET = 1'b0;
    tick();

    // Zero-wait read from slave 2.
    HSEL2 = 1'b1; HTRANS = 2'b10; HRDATA2 = 32'hA5A5_0002;
    tick();
    bus_idle();
    #1;
    check_resp("s2", 1'b1, 1'b0, 1'b0);
    check_eq("s2.hrdata", HRDATA, 32'hA5A5_0002);
    check_eq("s2.dsel", 32'(dut.dsel_q), 32'h04);
    tick();
    check_eq("s2.after_dsel", 32'(dut.dsel_q), 32'h0);

    // Slave 1 with three wait states; select must hold while stalled.
    HSEL1 = 1'b1; HTRANS = 2'b10;
    tick();
    bus_idle();
    HSEL3 = 1'b1; HTRANS = 2'b10;  // next address must not be captured while stalled
    HREADYOUT1 = 1'b0; HRDATA1 = 32'h1111_0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("s1.wait_hready", 32'(HREADY), 32'h0);
      check_eq("s1.wait_dsel", 32'(dut.dsel_q), 32'h02);
      tick();
    end
    HREADYOUT1 = 1'b1;
    bus_idle();
    #1;
    check_resp("s1.done", 1'b1, 1'b0, 1'b0);
    check_eq("s1.hrdata", HRDATA, 32'h1111_0001);
    tick();
    check_eq("s1.wcnt_clear", 32'(dut.wcnt_q), 32'h0);

    // Back-to-back unmapped accesses, then IDLE with no select.
    HTRANS = 2'b10;
    tick();
    check_resp("def.a_err1", 1'b0, 1'b1, 1'b0);
    check_eq("def.a_hrdata", HRDATA, 32'h0);
    tick();
    check_resp("def.a_err2", 1'b1, 1'b1, 1'b0);
    tick();
    HTRANS = 2'b00;
    #1;
    check_resp("def.b_err1", 1'b0, 1'b1, 1'b0);
    tick();
    check_resp("def.b_err2", 1'b1, 1'b1, 1'b0);
    tick();
    check_resp("def.idle", 1'b1, 1'b0, 1'b0);
    check_eq("def.idle_dsel", 32'(dut.dsel_q), 32'h0);

    // Hung slave 3: four wait states, then watchdog ERROR with one IRQ cycle.
    HSEL3 = 1'b1; HTRANS = 2'b10; HRDATA3 = 32'hDEAD_0003; HRESP3 = 1'b0;
    tick();
    bus_idle();
    HREADYOUT3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_resp("wd.wait", 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_resp("wd.err1", 1'b0, 1'b1, 1'b1);
    check_eq("wd.err1_hrdata", HRDATA, 32'h0);
    tick();
    check_resp("wd.err2", 1'b1, 1'b1, 1'b0);
    tick();
    check_resp("wd.after", 1'b1, 1'b0, 1'b0);
    check_eq("wd.wcnt", 32'(dut.wcnt_q), 32'h0);
    HREADYOUT3 = 1'b1;

    // Slave 0 ready on the very cycle the watchdog would expire: slave wins.
    HSEL0 = 1'b1; HTRANS = 2'b10; HRDATA0 = 32'h0C0C_0000;
    tick();
    bus_idle();
    HREADYOUT0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    check_eq("race.wcnt_pre", 32'(dut.wcnt_q), 32'h3);
    HREADYOUT0 = 1'b1;
    #1;
    check_resp("race.ready", 1'b1, 1'b0, 1'b0);
    check_eq("race.hrdata", HRDATA, 32'h0C0C_0000);
    tick();
    check_resp("race.after", 1'b1, 1'b0, 1'b0);
    check_eq("race.wcnt", 32'(dut.wcnt_q), 32'h0);

    // Reset in the first ERROR cycle abandons it immediately.
    HTRANS = 2'b10;
    tick();
    check_resp("rst.err1", 1'b0, 1'b1, 1'b0);
    HRESET = 1'b1;
    #1;
    check_resp("rst.async", 1'b1, 1'b0, 1'b0);
    check_eq("rst.state", 32'(dut.u_default_slave.st_q), 32'h0);
    HRESET = 1'b0;
    HSEL0 = 1'b1; HRDATA0 = 32'h5A5A_0000;
    tick();
    bus_idle();
    #1;
    check_resp("rst.s0", 1'b1, 1'b0, 1'b0);
    check_eq("rst.s0_hrdata", HRDATA, 32'h5A5A_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
